// File: rtl/cam_capture_pkg.sv
// Purpose : shared constants for the camera capture front-end.
// Contents: default frame geometry, bus widths, FSM state encoding and
//           byte-phase encoding used by cam_capture_ctrl and cam_byte_packer.
package cam_capture_pkg;

    localparam int unsigned DEF_H_WORDS     = 800;
    localparam int unsigned DEF_V_LINES     = 480;
    localparam int unsigned DEF_SKIP_FRAMES = 20;
    localparam int unsigned DEF_CNT_W       = 12;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] cap_state_t;

    localparam cap_state_t ST_SKIP   = 2'd0;
    localparam cap_state_t ST_WAIT   = 2'd1;
    localparam cap_state_t ST_ACTIVE = 2'd2;
    localparam cap_state_t ST_DROP   = 2'd3;

    // Byte phase within a pixel: high byte first, then low byte.
    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

endpackage

// File: rtl/cam_byte_packer.sv
// Purpose : two-flop synchronisers for vsync/href/data, edge detection and
//           byte-pair packing into 16-bit words (first byte in [15:8]).
// Ports   : cmos_pclk, rst_n_i        clock / async active-low reset
//           vsyn_i, href_i, data_i    raw camera pins
//           pack_en_i                 packing allowed (capture FSM in ACTIVE)
//           vs_rise_c_o, vs_fall_c_o  synchronised vsync edges
//           line_end_c_o              synchronised href fall
//           odd_byte_c_o              href fall with a lone high byte pending
//           word_valid_c_o            a word completes this cycle
//           word_o                    word register (valid the cycle after word_valid_c_o)
module cam_byte_packer
    import cam_capture_pkg::*;
(
    input  logic              cmos_pclk,
    input  logic              rst_n_i,
    input  logic              vsyn_i,
    input  logic              href_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              pack_en_i,
    output logic              vs_rise_c_o,
    output logic              vs_fall_c_o,
    output logic              line_end_c_o,
    output logic              odd_byte_c_o,
    output logic              word_valid_c_o,
    output logic [WORD_W-1:0] word_o
);

    // Index 0 is stage 1, index 1 is stage 2.
    logic [1:0]        vsyn_q;
    logic [1:0]        href_q;
    logic [BYTE_W-1:0] data_s1_q;
    logic [BYTE_W-1:0] data_s2_q;
    logic              phase_q;
    logic              phase_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic              href_rise_c;
    logic              byte_vld_c;

    // Synchronisers, phase and word registers.
    always_ff @(posedge cmos_pclk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vsyn_q    <= '0;
            href_q    <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            phase_q   <= PH_HI;
            word_q    <= '0;
        end else begin
            vsyn_q    <= {vsyn_q[0], vsyn_i};
            href_q    <= {href_q[0], href_i};
            data_s1_q <= data_i;
            data_s2_q <= data_s1_q;
            phase_q   <= phase_d;
            word_q    <= word_d;
        end
    end

    // Edges are seen between stage 1 and stage 2; the byte in stage 2 is the
    // one belonging to the current href level, so the last byte of a line is
    // still processed in the href-fall cycle.
    assign vs_rise_c_o    = vsyn_q[0] & ~vsyn_q[1];
    assign vs_fall_c_o    = ~vsyn_q[0] & vsyn_q[1];
    assign href_rise_c    = href_q[0] & ~href_q[1];
    assign line_end_c_o   = ~href_q[0] & href_q[1];
    assign byte_vld_c     = pack_en_i & href_q[1];
    assign word_valid_c_o = byte_vld_c & (phase_q == PH_LO);
    assign odd_byte_c_o   = line_end_c_o & byte_vld_c & (phase_q == PH_HI);
    assign word_o         = word_q;

    // Phase toggle and byte placement.
    always_comb begin
        phase_d = phase_q;
        word_d  = word_q;
        if (!pack_en_i || href_rise_c) begin
            phase_d = PH_HI;
        end else if (byte_vld_c) begin
            if (phase_q == PH_HI) begin
                word_d[WORD_W-1 -: BYTE_W] = data_s2_q;
            end else begin
                word_d[BYTE_W-1:0] = data_s2_q;
            end
            phase_d = ~phase_q;
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Purpose : camera capture control: start-up frame skipping, frame/line
//           tracking, FIFO write strobes and sticky geometry/overflow flags.
// Ports   : cmos_pclk, rst_133           clock / async active-low reset
//           cmos_vsyn/href/data          camera pins
//           err_clr                      clears sticky error flags
//           fifo_full, fifo_wr_en/_data  downstream FIFO write port
//           capture_en, frame_start/done frame status
//           lines_last, words_last       geometry of last closed frame / line
//           err_line, err_frame, err_ovf sticky error flags
module cam_capture_ctrl
    import cam_capture_pkg::*;
#(
    parameter int unsigned H_WORDS     = DEF_H_WORDS,
    parameter int unsigned V_LINES     = DEF_V_LINES,
    parameter int unsigned SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              cmos_pclk,
    input  logic              rst_133,
    input  logic              cmos_vsyn,
    input  logic              cmos_href,
    input  logic [BYTE_W-1:0] cmos_data,
    input  logic              err_clr,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_wr_data,
    output logic              capture_en,
    output logic              frame_start,
    output logic              frame_done,
    output logic [CNT_W-1:0]  lines_last,
    output logic [CNT_W-1:0]  words_last,
    output logic              err_line,
    output logic              err_frame,
    output logic              err_ovf
);

    localparam int unsigned SKIP_W = $clog2(SKIP_FRAMES + 1);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    cap_state_t        state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  lines_last_q, lines_last_d;
    logic [CNT_W-1:0]  words_last_q, words_last_d;
    logic              capture_en_q, capture_en_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              fifo_wr_en_q, fifo_wr_en_d;
    logic              err_line_q, err_line_d;
    logic              err_frame_q, err_frame_d;
    logic              err_ovf_q, err_ovf_d;

    logic              vs_rise_c, vs_fall_c, line_end_c, odd_byte_c, word_valid_c;
    logic [CNT_W-1:0]  word_inc_c, word_now_c, line_inc_c, line_total_c;
    logic              ovf_now_c;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    cam_byte_packer u_packer (
        .cmos_pclk      (cmos_pclk),
        .rst_n_i        (rst_n),
        .vsyn_i         (cmos_vsyn),
        .href_i         (cmos_href),
        .data_i         (cmos_data),
        .pack_en_i      (state_q == ST_ACTIVE),
        .vs_rise_c_o    (vs_rise_c),
        .vs_fall_c_o    (vs_fall_c),
        .line_end_c_o   (line_end_c),
        .odd_byte_c_o   (odd_byte_c),
        .word_valid_c_o (word_valid_c),
        .word_o         (fifo_wr_data)
    );

    // Saturating counts including the word that completes this cycle.
    assign word_inc_c = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
    assign word_now_c = word_valid_c ? word_inc_c : word_cnt_q;
    assign line_inc_c = (&line_cnt_q) ? line_cnt_q : line_cnt_q + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SKIP;
            skip_cnt_q    <= '0;
            line_cnt_q    <= '0;
            word_cnt_q    <= '0;
            lines_last_q  <= '0;
            words_last_q  <= '0;
            capture_en_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            fifo_wr_en_q  <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            line_cnt_q    <= line_cnt_d;
            word_cnt_q    <= word_cnt_d;
            lines_last_q  <= lines_last_d;
            words_last_q  <= words_last_d;
            capture_en_q  <= capture_en_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            fifo_wr_en_q  <= fifo_wr_en_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    // Next-state, counters and error logic. err_clr is applied first so a
    // same-cycle error event overrides it.
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        line_cnt_d    = line_cnt_q;
        word_cnt_d    = word_cnt_q;
        lines_last_d  = lines_last_q;
        words_last_d  = words_last_q;
        capture_en_d  = capture_en_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        fifo_wr_en_d  = 1'b0;
        err_line_d    = err_clr ? 1'b0 : err_line_q;
        err_frame_d   = err_clr ? 1'b0 : err_frame_q;
        err_ovf_d     = err_clr ? 1'b0 : err_ovf_q;
        line_total_c  = line_cnt_q;
        ovf_now_c     = 1'b0;

        case (state_q)
            ST_SKIP: begin
                if (vs_rise_c) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q == SKIP_W'(SKIP_FRAMES - 1)) begin
                        capture_en_d = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (vs_fall_c) begin
                    frame_start_d = 1'b1;
                    line_cnt_d    = '0;
                    word_cnt_d    = '0;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (word_valid_c) begin
                    word_cnt_d = word_inc_c;
                    if (fifo_full) ovf_now_c    = 1'b1;
                    else           fifo_wr_en_d = 1'b1;
                end
                // Line close happens before any same-cycle frame close.
                if (line_end_c) begin
                    words_last_d = word_now_c;
                    if (word_now_c != CNT_W'(H_WORDS) || odd_byte_c) err_line_d = 1'b1;
                    line_total_c = line_inc_c;
                    line_cnt_d   = line_inc_c;
                    word_cnt_d   = '0;
                end
                if (ovf_now_c) err_ovf_d = 1'b1;
                if (vs_rise_c) begin
                    lines_last_d = line_total_c;
                    if (line_total_c != CNT_W'(V_LINES)) err_frame_d = 1'b1;
                    frame_done_d = ~ovf_now_c;
                    state_d      = ST_WAIT;
                end else if (vs_fall_c) begin
                    // Vsync fell again without a rise: restart the frame.
                    frame_start_d = 1'b1;
                    line_cnt_d    = '0;
                    word_cnt_d    = '0;
                end else if (ovf_now_c) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (vs_rise_c) begin
                    lines_last_d = line_cnt_q;
                    state_d      = ST_WAIT;
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    assign fifo_wr_en  = fifo_wr_en_q;
    assign capture_en  = capture_en_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign lines_last  = lines_last_q;
    assign words_last  = words_last_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with reduced frame geometry.
// Expected FIFO words and their write cycles go into a scoreboard queue
// as bytes are driven; a negedge monitor pops and compares on each write.
module tb_cam_capture_ctrl;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 3;
    localparam int unsigned SKIP = 3;
    localparam int unsigned CW   = 12;

    logic          cmos_pclk;
    logic          rst_133;
    logic          cmos_vsyn;
    logic          cmos_href;
    logic [7:0]    cmos_data;
    logic          err_clr;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [15:0]   fifo_wr_data;
    logic          capture_en;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] lines_last;
    logic [CW-1:0] words_last;
    logic          err_line;
    logic          err_frame;
    logic          err_ovf;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    int   fd_cnt   = 0;
    int   fs_cnt   = 0;
    int   exp_wr   = 0;
    int   exp_fd   = 0;
    int   exp_fs   = 0;
    int   byte_k   = 0;
    logic prev_wr  = 1'b0;

    cam_capture_ctrl #(
        .H_WORDS     (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SKIP),
        .CNT_W       (CW)
    ) dut (
        .cmos_pclk    (cmos_pclk),
        .rst_133      (rst_133),
        .cmos_vsyn    (cmos_vsyn),
        .cmos_href    (cmos_href),
        .cmos_data    (cmos_data),
        .err_clr      (err_clr),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .capture_en   (capture_en),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .lines_last   (lines_last),
        .words_last   (words_last),
        .err_line     (err_line),
        .err_frame    (err_frame),
        .err_ovf      (err_ovf)
    );

    initial cmos_pclk = 1'b0;
    always #5 cmos_pclk = ~cmos_pclk;

    always @(posedge cmos_pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next scoreboard entry in
    // data and cycle, and strobes are never back to back.
    always @(negedge cmos_pclk) begin : mon
        exp_t e;
        if (fifo_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            chk("wr_gap", 32'(prev_wr), 32'd0);
            chk("wr_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_data", 32'(fifo_wr_data), 32'(e.word));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_wr <= fifo_wr_en;
        if (frame_done)  fd_cnt <= fd_cnt + 1;
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    task automatic tick();
        @(negedge cmos_pclk);
    endtask

    task automatic vs_pulse();
        cmos_vsyn = 1'b1;
        repeat (3) tick();
        cmos_vsyn = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_open();
        cmos_vsyn = 1'b0;
        byte_k    = 0;
        exp_fs++;
        repeat (3) tick();
    endtask

    task automatic frame_close();
        cmos_vsyn = 1'b1;
        repeat (4) tick();
    endtask

    // Drives one href line. Word w completes with byte 2w+1 and is written
    // 3 cycles after that byte is driven. fifo_full rises when byte full_at
    // is driven; words written before then are still expected.
    task automatic drive_line(input int nbytes, input bit push, input int full_at,
                              input bit clr_at_close, input bit vs_at_close);
        logic [7:0] hi;
        exp_t       e;
        hi = 8'h00;
        cmos_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            cmos_data = 8'(18 + 34 * byte_k);
            byte_k++;
            if (i == full_at) fifo_full = 1'b1;
            if (i % 2 == 0) begin
                hi = cmos_data;
            end else if (push && (full_at < 0 || i + 3 <= full_at)) begin
                e.word = {hi, cmos_data};
                e.cyc  = cyc + 3;
                sb.push_back(e);
                exp_wr++;
            end
            tick();
        end
        cmos_href = 1'b0;
        if (vs_at_close) cmos_vsyn = 1'b1;
        tick();
        if (clr_at_close) err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   32'(fifo_wr_en),   32'd0);
        chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
        chk({tag, "_cap_en"},  32'(capture_en),   32'd0);
        chk({tag, "_fstart"},  32'(frame_start),  32'd0);
        chk({tag, "_fdone"},   32'(frame_done),   32'd0);
        chk({tag, "_lines"},   32'(lines_last),   32'd0);
        chk({tag, "_words"},   32'(words_last),   32'd0);
        chk({tag, "_eline"},   32'(err_line),     32'd0);
        chk({tag, "_eframe"},  32'(err_frame),    32'd0);
        chk({tag, "_eovf"},    32'(err_ovf),      32'd0);
    endtask

    initial begin
        rst_133   = 1'b0;
        cmos_vsyn = 1'b0;
        cmos_href = 1'b0;
        cmos_data = 8'h00;
        err_clr   = 1'b0;
        fifo_full = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_133 = 1'b1;
        repeat (4) tick();

        // Start-up skipping: data present, no capture for SKIP-1 rises.
        for (int p = 0; p < int'(SKIP) - 1; p++) begin
            vs_pulse();
            drive_line(8, 1'b0, -1, 1'b0, 1'b0);
            chk("skip_cap_en", 32'(capture_en), 32'd0);
        end
        cmos_vsyn = 1'b1;
        tick();
        chk("cap_en_before", 32'(capture_en), 32'd0);
        tick();
        chk("cap_en_rise", 32'(capture_en), 32'd1);
        tick();

        // First frame: frame_start two cycles after vsync falls.
        cmos_vsyn = 1'b0;
        byte_k    = 0;
        exp_fs++;
        tick();
        chk("fstart_early", 32'(frame_start), 32'd0);
        tick();
        chk("fstart_pulse", 32'(frame_start), 32'd1);
        tick();
        chk("fstart_end", 32'(frame_start), 32'd0);
        for (int l = 0; l < int'(V); l++) drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        frame_close();
        exp_fd++;
        chk("f1_done_cnt", 32'(fd_cnt), 32'(exp_fd));
        chk("f1_lines", 32'(lines_last), 32'(V));
        chk("f1_words", 32'(words_last), 32'(H));
        chk("f1_eline", 32'(err_line), 32'd0);
        chk("f1_eframe", 32'(err_frame), 32'd0);
        chk("f1_eovf", 32'(err_ovf), 32'd0);
        chk("f1_wr_cnt", 32'(wr_cnt), 32'(exp_wr));

        // Odd-length lines, err_clr alone and err_clr colliding with an error.
        frame_open();
        drive_line(7, 1'b1, -1, 1'b0, 1'b0);
        chk("odd_words", 32'(words_last), 32'(H - 1));
        chk("odd_eline", 32'(err_line), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_eline", 32'(err_line), 32'd0);
        drive_line(7, 1'b1, -1, 1'b1, 1'b0);
        chk("clr_vs_err", 32'(err_line), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr2_eline", 32'(err_line), 32'd0);
        drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        chk("odd_f_words", 32'(words_last), 32'(H));
        chk("odd_f_eline", 32'(err_line), 32'd0);
        frame_close();
        exp_fd++;
        chk("odd_f_done", 32'(fd_cnt), 32'(exp_fd));
        chk("odd_f_lines", 32'(lines_last), 32'(V));
        chk("odd_f_eframe", 32'(err_frame), 32'd0);

        // Overflow mid-line: rest of frame dropped, no frame_done.
        frame_open();
        drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        drive_line(8, 1'b1, 6, 1'b0, 1'b0);
        fifo_full = 1'b0;
        drive_line(8, 1'b0, -1, 1'b0, 1'b0);
        frame_close();
        chk("ovf_eovf", 32'(err_ovf), 32'd1);
        chk("ovf_no_done", 32'(fd_cnt), 32'(exp_fd));
        chk("ovf_wr_cnt", 32'(wr_cnt), 32'(exp_wr));

        // Next frame captures normally; err_ovf stays until cleared.
        frame_open();
        for (int l = 0; l < int'(V); l++) drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        frame_close();
        exp_fd++;
        chk("post_ovf_done", 32'(fd_cnt), 32'(exp_fd));
        chk("post_ovf_lines", 32'(lines_last), 32'(V));
        chk("post_ovf_sticky", 32'(err_ovf), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_eovf", 32'(err_ovf), 32'd0);

        // Short frame; last href fall coincides with vsync rise.
        frame_open();
        drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        drive_line(8, 1'b1, -1, 1'b0, 1'b1);
        tick();
        exp_fd++;
        chk("short_lines", 32'(lines_last), 32'(V - 1));
        chk("short_eframe", 32'(err_frame), 32'd1);
        chk("short_words", 32'(words_last), 32'(H));
        chk("short_eline", 32'(err_line), 32'd0);
        chk("short_done", 32'(fd_cnt), 32'(exp_fd));
        chk("frames_started", 32'(fs_cnt), 32'(exp_fs));

        // Reset in the middle of a line.
        frame_open();
        cmos_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmos_data = 8'(18 + 34 * i);
            tick();
        end
        rst_133 = 1'b0;
        #1;
        chk_all_zero("midrst");
        cmos_href = 1'b0;
        repeat (3) tick();
        rst_133 = 1'b1;
        repeat (4) tick();
        chk("rel_cap_en", 32'(capture_en), 32'd0);
        for (int p = 0; p < int'(SKIP) - 1; p++) begin
            vs_pulse();
            chk("reskip_cap_en", 32'(capture_en), 32'd0);
        end
        cmos_vsyn = 1'b1;
        tick();
        chk("recap_before", 32'(capture_en), 32'd0);
        tick();
        chk("recap_rise", 32'(capture_en), 32'd1);
        tick();

        // Capture works again after the re-skip.
        frame_open();
        for (int l = 0; l < int'(V); l++) drive_line(8, 1'b1, -1, 1'b0, 1'b0);
        frame_close();
        exp_fd++;
        chk("final_done", 32'(fd_cnt), 32'(exp_fd));
        chk("final_lines", 32'(lines_last), 32'(V));
        chk("final_eframe", 32'(err_frame), 32'd0);
        chk("final_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Camera front-end capture stage in the cmos_pclk domain. It synchronises vsync/href, skips start-up frames, packs byte pairs into 16-bit RGB565 words and drives the write port of the camera-to-SDRAM dual-clock FIFO. It directly feeds the 133 MHz SDRAM write sequencer, which drains that FIFO in 512-word bursts. It also flags frame-geometry and overflow errors for the board diagnostics.

Parameters:
H_WORDS, 800, expected 16-bit words per active line
V_LINES, 480, expected active lines per frame
SKIP_FRAMES, 20, vsync rising edges ignored after reset before capture is enabled
CNT_W, 12, width of pixel and line counters

Ports:
cmos_pclk  in  1  camera pixel clock; all logic on its rising edge
rst_133  in  1  asynchronous, active-low reset
cmos_vsyn  in  1  camera vsync; high = vertical blanking
cmos_href  in  1  camera href; high = active byte stream
cmos_data  in  8  camera byte bus
err_clr  in  1  single-cycle pulse; clears all sticky error flags
fifo_full  in  1  write-side full flag of the downstream FIFO
fifo_wr_en  out  1  single-cycle write strobe
fifo_wr_data  out  16  packed word, first byte in [15:8]
capture_en  out  1  high once SKIP_FRAMES vsync rises have been seen
frame_start  out  1  pulse on synchronised vsync fall while capture_en is high
frame_done  out  1  pulse on vsync rise that closes a frame captured without overflow
lines_last  out  CNT_W  line count of the last closed frame
words_last  out  CNT_W  word count of the last closed line
err_line  out  1  sticky: a line closed with word count not equal to H_WORDS, or with an odd trailing byte
err_frame  out  1  sticky: a frame closed with line count not equal to V_LINES
err_ovf  out  1  sticky: a word was dropped because fifo_full was high

Behaviour:
- Reset is asserted asynchronously and released synchronously to cmos_pclk. While in reset, every output and counter is 0 and the state is SKIP.
- vsyn, href and data each pass through 2 flops. Edges are detected between stage 1 and stage 2.
- State machine:
  - SKIP: count vsync rises; at the rise that makes the count equal SKIP_FRAMES, set capture_en and go to WAIT. capture_en then stays high until reset.
  - WAIT: on vsync fall, pulse frame_start, clear the line counter, go to ACTIVE.
  - ACTIVE: pack bytes.
    - On vsync rise: pulse frame_done, load lines_last, set err_frame on mismatch, go to WAIT.
    - If a write is needed while fifo_full is high: drop the word, set err_ovf, go to DROP.
  - DROP: ignore data. On vsync rise, load lines_last with no frame_done pulse and go to WAIT.
- Packing runs only in ACTIVE.
  - The byte phase resets to 0 on href rise.
  - Phase 0 latches the byte into [15:8]. Phase 1 forms the word.
  - The word is presented with fifo_wr_en=1 on the next cycle, 3 pclk after the second byte is on the pins.
  - fifo_wr_en is never high for 2 consecutive cycles.
- Line close on href fall:
  - words_last is loaded with the line's word count (saturating at 2^CNT_W-1).
  - err_line is set if words_last is not equal to H_WORDS, or if a phase-0 byte is pending; that odd byte is discarded.
  - The line counter increments, saturating.
- Same-cycle href fall and vsync rise: the line is closed first and counted in lines_last.
- err_clr together with a new error event in the same cycle: the error wins.
- A vsync fall while in ACTIVE (no rise seen) restarts the frame: frame_start is pulsed and the counters are cleared; no error is raised.

Decomposition:
- Package cam_capture_pkg holds:
  - the state enum SKIP/WAIT/ACTIVE/DROP;
  - the default values of H_WORDS, V_LINES and SKIP_FRAMES;
  - the byte-phase constants.
- Sub-module cam_byte_packer contains:
  - the synchroniser flops;
  - the phase toggle;
  - the word register.
  It outputs word and word_valid, plus an odd_byte flag at href fall. The top module holds the FSM, counters and error logic.

Test Plan:
- Reset, then 20 vsync pulses with data → capture_en rises at the 20th rise; no fifo_wr_en before then; frame_start at the next vsync fall.
- Frame of 480 lines × 1600 bytes (bytes 0x12, 0x34, …) → 384000 writes, first word 0x1234; frame_done once; lines_last=480; no error flags.
- Line of 1599 bytes → words_last=799, err_line=1; a following err_clr pulse clears it.
- fifo_full held high mid-line → err_ovf=1; no writes until the next frame; no frame_done for that frame; next frame captures normally.
- Frame of 479 lines, with href fall and vsync rise in the same cycle → lines_last=479, err_frame=1.
- rst_133 asserted mid-line → all outputs 0 immediately; after release capture_en stays low until 20 more vsync rises.
